// File: rtl/window_scan_ctrl.sv
// window_scan_ctrl
//
// Raster-scans a frame of IMG_H x IMG_W window positions. It issues one read strobe per 3x3
// window to the window memory. Each result write is issued PIPE_LAT cycles after its read,
// carrying the same coordinate as that read. A frame starts from IDLE on `start`. When the
// write pipeline has drained, `done` pulses for one cycle.
//
// Optional feature: define WSC_STALL_EN to let `stall` freeze the scan. Without the macro, the
// `stall` port is present but ignored.
//
// Ports
//   clk             rising-edge clock
//   rst             synchronous, active-high reset
//   start           frame request, sampled only in IDLE
//   stall           downstream hold (WSC_STALL_EN builds only)
//   rd              window read strobe
//   rd_row, rd_col  top-left coordinate of the window being read
//   wr              result write strobe
//   wr_row, wr_col  destination coordinate of the result
//   busy            high while scanning or draining
//   done            one-cycle frame-complete pulse

module window_scan_ctrl #(
  parameter int unsigned IMG_W    = 64,
  parameter int unsigned IMG_H    = 64,
  parameter int unsigned PIPE_LAT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stall,
  output logic       rd,
  output logic [6:0] rd_row,
  output logic [6:0] rd_col,
  output logic       wr,
  output logic [6:0] wr_row,
  output logic [6:0] wr_col,
  output logic       busy,
  output logic       done
);

  localparam logic [6:0] LastRow   = 7'(IMG_H - 1);
  localparam logic [6:0] LastCol   = 7'(IMG_W - 1);
  localparam logic [3:0] DrainLast = 4'(PIPE_LAT);

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDrain,
    StDone
  } state_e;

  state_e state_q, state_d;

  // Scan counters: the coordinate to be issued on the next unfrozen edge.
  logic [6:0] row_q, row_d;
  logic [6:0] col_q, col_d;

  // Registered read strobe and the coordinate it refers to.
  logic       rd_q, rd_d;
  logic [6:0] rd_row_q, rd_row_d;
  logic [6:0] rd_col_q, rd_col_d;

  logic [3:0] drain_cnt_q, drain_cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  // Write pipeline: stage 0 captures the presented read; the last stage drives the write port.
  logic [PIPE_LAT-1:0] pipe_vld_q, pipe_vld_d;
  logic [6:0]          pipe_row_q [PIPE_LAT];
  logic [6:0]          pipe_row_d [PIPE_LAT];
  logic [6:0]          pipe_col_q [PIPE_LAT];
  logic [6:0]          pipe_col_d [PIPE_LAT];

  // A freeze holds every register. The read and write strobes are masked in the same cycle, so
  // a held strobe is presented only once, when the stall lifts.
  logic freeze;

`ifdef WSC_STALL_EN
  assign freeze = stall & ((state_q == StScan) | (state_q == StDrain));
`else
  logic unused_stall;
  assign unused_stall = stall;
  assign freeze       = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    rd_d        = rd_q;
    rd_row_d    = rd_row_q;
    rd_col_d    = rd_col_q;
    drain_cnt_d = drain_cnt_q;
    pipe_vld_d  = pipe_vld_q;
    pipe_row_d  = pipe_row_q;
    pipe_col_d  = pipe_col_q;

    if (!freeze) begin
      rd_d = 1'b0;

      pipe_vld_d[0] = rd_q;
      pipe_row_d[0] = rd_row_q;
      pipe_col_d[0] = rd_col_q;
      for (int unsigned i = 1; i < PIPE_LAT; i++) begin
        pipe_vld_d[i] = pipe_vld_q[i-1];
        pipe_row_d[i] = pipe_row_q[i-1];
        pipe_col_d[i] = pipe_col_q[i-1];
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d  = StScan;
            row_d    = '0;
            col_d    = '0;
            rd_row_d = '0;
            rd_col_d = '0;
          end
        end
        StScan: begin
          rd_d     = 1'b1;
          rd_row_d = row_q;
          rd_col_d = col_q;
          if ((row_q == LastRow) && (col_q == LastCol)) begin
            // Counters park on the last window; they never wrap past the frame end.
            state_d     = StDrain;
            drain_cnt_d = '0;
          end else if (col_q == LastCol) begin
            col_d = '0;
            row_d = row_q + 7'd1;
          end else begin
            col_d = col_q + 7'd1;
          end
        end
        StDrain: begin
          // The last read is still in rd_q on entry, so PIPE_LAT+1 drain cycles empty the
          // pipeline.
          if (drain_cnt_q == DrainLast) begin
            state_d = StDone;
          end else begin
            drain_cnt_d = drain_cnt_q + 4'd1;
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    busy_d = (state_d == StScan) || (state_d == StDrain);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      row_q       <= '0;
      col_q       <= '0;
      rd_q        <= 1'b0;
      rd_row_q    <= '0;
      rd_col_q    <= '0;
      drain_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pipe_vld_q  <= '0;
      pipe_row_q  <= '{default: '0};
      pipe_col_q  <= '{default: '0};
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      rd_q        <= rd_d;
      rd_row_q    <= rd_row_d;
      rd_col_q    <= rd_col_d;
      drain_cnt_q <= drain_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_row_q  <= pipe_row_d;
      pipe_col_q  <= pipe_col_d;
    end
  end

  assign rd     = rd_q & ~freeze;
  assign rd_row = rd_row_q;
  assign rd_col = rd_col_q;
  assign wr     = pipe_vld_q[PIPE_LAT-1] & ~freeze;
  assign wr_row = pipe_row_q[PIPE_LAT-1];
  assign wr_col = pipe_col_q[PIPE_LAT-1];
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
